// File: rtl/conv_layer_sched.sv
// Layer sequencer for the column-parallel conv array: walks oc -> ic -> column,
// issues weight/fmap RAM reads, PE control flags and tagged output-column valids.
module conv_layer_sched #(
  parameter int COLS     = 56,
  parameter int IC       = 64,
  parameter int OC       = 64,
  parameter int PIPE_LAT = 2,
  parameter int FA_W     = 12,
  parameter int WA_W     = 12,
  localparam int OC_W    = (OC > 1) ? $clog2(OC) : 1,
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic             fmap_rd,
  output logic [FA_W-1:0]  fmap_addr,
  output logic             wht_rd,
  output logic [WA_W-1:0]  wht_addr,
  output logic             wht_load,
  output logic             pe_en,
  output logic             acc_clr,
  output logic             acc_last,
  output logic             out_valid,
  output logic [OC_W-1:0]  out_oc,
  output logic [COL_W-1:0] out_col
);
  localparam int IC_W = (IC > 1) ? $clog2(IC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WHT_RD, S_WHT_LD, S_COL, S_DRAIN} state_t;
  state_t state, state_nxt;

  logic [OC_W-1:0]  oc;
  logic [IC_W-1:0]  ic;
  logic [COL_W-1:0] col;
  logic             col_last, ic_last, oc_last, pipe_empty;

  logic             pe_en_p0, acc_clr_p0, acc_last_p0;
  logic [OC_W-1:0]  oc_p0;
  logic [COL_W-1:0] col_p0;

  logic [PIPE_LAT-1:0] vld_pn;
  logic [OC_W-1:0]     oc_pn  [PIPE_LAT];
  logic [COL_W-1:0]    col_pn [PIPE_LAT];

  assign col_last   = (col == COL_W'(COLS - 1));
  assign ic_last    = (ic == IC_W'(IC - 1));
  assign oc_last    = (oc == OC_W'(OC - 1));
  assign pipe_empty = !pe_en_p0 && (vld_pn == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!hold) begin
      case (state)
        S_IDLE:   if (start) state_nxt = S_WHT_RD;
        S_WHT_RD: state_nxt = S_WHT_LD;
        S_WHT_LD: state_nxt = S_COL;
        S_COL:    if (col_last) state_nxt = (ic_last && oc_last) ? S_DRAIN : S_WHT_RD;
        S_DRAIN:  if (pipe_empty) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Strobes are gated by hold so a frozen cycle never issues a RAM access.
  always_comb begin
    wht_rd    = (state == S_WHT_RD) && !hold;
    wht_load  = (state == S_WHT_LD) && !hold;
    fmap_rd   = (state == S_COL) && !hold;
    done      = (state == S_DRAIN) && pipe_empty && !hold;
    busy      = (state != S_IDLE) && !done;
    fmap_addr = fmap_rd ? (FA_W'(ic) * FA_W'(COLS) + FA_W'(col)) : '0;
    wht_addr  = wht_rd ? (WA_W'(oc) * WA_W'(IC) + WA_W'(ic)) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oc  <= '0;
      ic  <= '0;
      col <= '0;
    end else if (!hold && state == S_COL) begin
      if (!col_last) begin
        col <= col + 1'b1;
      end else begin
        col <= '0;
        if (!ic_last) begin
          ic <= ic + 1'b1;
        end else begin
          ic <= '0;
          oc <= oc_last ? '0 : oc + 1'b1;
        end
      end
    end
  end

  // p0: RAM read-latency stage; pn: array pipeline latency stages
  always_ff @(posedge clk) begin
    if (rst) begin
      pe_en_p0    <= 1'b0;
      acc_clr_p0  <= 1'b0;
      acc_last_p0 <= 1'b0;
      oc_p0       <= '0;
      col_p0      <= '0;
      vld_pn      <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        oc_pn[i]  <= '0;
        col_pn[i] <= '0;
      end
    end else if (!hold) begin
      pe_en_p0    <= fmap_rd;
      acc_clr_p0  <= fmap_rd && (ic == '0);
      acc_last_p0 <= fmap_rd && ic_last;
      oc_p0       <= oc;
      col_p0      <= col;
      vld_pn[0]   <= pe_en_p0 && acc_last_p0;
      oc_pn[0]    <= oc_p0;
      col_pn[0]   <= col_p0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_pn[i] <= vld_pn[i-1];
        oc_pn[i]  <= oc_pn[i-1];
        col_pn[i] <= col_pn[i-1];
      end
    end
  end

  assign pe_en     = pe_en_p0;
  assign acc_clr   = acc_clr_p0;
  assign acc_last  = acc_last_p0;
  assign out_valid = vld_pn[PIPE_LAT-1];
  assign out_oc    = oc_pn[PIPE_LAT-1];
  assign out_col   = col_pn[PIPE_LAT-1];

endmodule
